// File: rtl/pat_frame_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pat_frame_tx : serial frame transmitter, sends sync header PAT, the payload
//                (both MSB first), then an idle gap.          Rev 1.0
// ---------------------------------------------------------------------------
module pat_frame_tx #(
  parameter int                 SEQ_LEN    = 8,
  parameter logic [SEQ_LEN-1:0] PAT        = 8'b1010_1100,
  parameter int                 DATA_W     = 8,
  parameter int                 GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              abort_i,
  output logic              x_o,
  output logic              x_vld_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int MAXC = (SEQ_LEN > DATA_W) ?
                        ((SEQ_LEN > GAP_CYCLES) ? SEQ_LEN : GAP_CYCLES) :
                        ((DATA_W > GAP_CYCLES) ? DATA_W : GAP_CYCLES);
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_DATA = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t              state_q;
  logic [SEQ_LEN-1:0]  hdr_q;
  logic [DATA_W-1:0]   data_q;
  logic [CW-1:0]       cnt_q;
  logic                x_q;
  logic                vld_q;
  logic                done_q;

  assign in_ready_o = (state_q == S_IDLE) && !abort_i;
  assign busy_o     = (state_q != S_IDLE);
  assign x_o        = x_q;
  assign x_vld_o    = vld_q;
  assign done_o     = done_q;

  // cnt_q counts cycles already presented within the current phase
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      hdr_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      x_q     <= 1'b0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (in_valid_i && in_ready_o) begin
            data_q  <= in_data_i;
            hdr_q   <= PAT << 1;
            x_q     <= PAT[SEQ_LEN-1];
            vld_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_HDR;
          end
        end
        S_HDR: begin
          if (abort_i) begin
            x_q     <= 1'b0;
            vld_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else if (cnt_q == CW'(SEQ_LEN - 1)) begin
            x_q     <= data_q[DATA_W-1];
            data_q  <= data_q << 1;
            cnt_q   <= '0;
            done_q  <= (DATA_W == 1);
            state_q <= S_DATA;
          end else begin
            x_q   <= hdr_q[SEQ_LEN-1];
            hdr_q <= hdr_q << 1;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (abort_i) begin
            x_q     <= 1'b0;
            vld_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else if (cnt_q == CW'(DATA_W - 1)) begin
            x_q     <= 1'b0;
            vld_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
          end else begin
            x_q    <= data_q[DATA_W-1];
            data_q <= data_q << 1;
            cnt_q  <= cnt_q + 1'b1;
            done_q <= (cnt_q == CW'(DATA_W - 2));
          end
        end
        S_GAP: begin
          if (abort_i || (cnt_q == CW'(GAP_CYCLES - 1))) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pat_frame_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pat_frame_tx : scoreboard bench for pat_frame_tx.        Rev 1.0
// ---------------------------------------------------------------------------
module tb_pat_frame_tx;

  localparam int          SEQ_LEN = 8;
  localparam logic [7:0]  PAT     = 8'hAC;
  localparam int          DATA_W  = 8;
  localparam int          GAP     = 2;
  localparam int          FLEN    = SEQ_LEN + DATA_W;
  localparam int          TOTAL   = FLEN + GAP;

  logic              clk;
  logic              reset;
  logic [DATA_W-1:0] in_data_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic              abort_i;
  logic              x_o;
  logic              x_vld_o;
  logic              busy_o;
  logic              done_o;

  pat_frame_tx #(
    .SEQ_LEN   (SEQ_LEN),
    .PAT       (PAT),
    .DATA_W    (DATA_W),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data_i (in_data_i),
    .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o),
    .abort_i   (abort_i),
    .x_o       (x_o),
    .x_vld_o   (x_vld_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         rem     = 0;   // busy cycles left, counting the current one
  logic [1:0] exp_q[$];      // {x, done} per expected frame bit

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame = PAT followed by payload, MSB first; done marks the final bit
  task automatic push_frame(input logic [DATA_W-1:0] d);
    logic [FLEN-1:0] f;
    f = {PAT, d};
    for (int i = 0; i < FLEN; i++)
      exp_q.push_back({f[FLEN-1-i], (i == FLEN-1) ? 1'b1 : 1'b0});
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (x_vld_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_bit", 32'd1, 32'd0);
        end else begin
          logic [1:0] e;
          e = exp_q.pop_front();
          chk("x_o", {31'd0, x_o}, {31'd0, e[1]});
          chk("done_o", {31'd0, done_o}, {31'd0, e[0]});
        end
      end else begin
        chk("idle_x_o", {31'd0, x_o}, 32'd0);
        chk("idle_done_o", {31'd0, done_o}, 32'd0);
      end
    end
  end

  // Called just after a rising edge: drives inputs for the coming edge and
  // advances the reference model by one cycle.
  task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic a);
    int nrem;
    in_valid_i = v;
    in_data_i  = d;
    abort_i    = a;
    #1;
    chk("busy_o", {31'd0, busy_o}, {31'd0, (rem != 0)});
    chk("in_ready_o", {31'd0, in_ready_o}, {31'd0, (rem == 0) && !a});
    chk("x_vld_o", {31'd0, x_vld_o}, {31'd0, (rem > GAP)});
    if (rem == 0) begin
      if (v && !a) begin
        push_frame(d);
        nrem = TOTAL;
      end else begin
        nrem = 0;
      end
    end else if (a) begin
      while (exp_q.size() > ((rem > GAP) ? 1 : 0)) void'(exp_q.pop_back());
      nrem = 0;
    end else begin
      nrem = rem - 1;
    end
    @(posedge clk);
    #1;
    rem = nrem;
  endtask

  task automatic reset_mid();
    reset = 1'b1;
    #1;
    chk("rst_x_o", {31'd0, x_o}, 32'd0);
    chk("rst_x_vld_o", {31'd0, x_vld_o}, 32'd0);
    chk("rst_done_o", {31'd0, done_o}, 32'd0);
    chk("rst_busy_o", {31'd0, busy_o}, 32'd0);
    exp_q.delete();
    rem = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    in_data_i  = '0;
    in_valid_i = 1'b0;
    abort_i    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, busy_o}, 32'd0);
    chk("reset_vld", {31'd0, x_vld_o}, 32'd0);
    chk("reset_x", {31'd0, x_o}, 32'd0);
    chk("reset_done", {31'd0, done_o}, 32'd0);
    reset = 1'b0;
    #1;
    chk("reset_ready", {31'd0, in_ready_o}, 32'd1);

    // basic frame
    step(1'b1, 8'h5A, 1'b0);
    repeat (TOTAL + 1) step(1'b0, 8'($urandom), 1'b0);

    // back-to-back frames with valid held high
    step(1'b1, 8'hFF, 1'b0);
    repeat (TOTAL + 1) step(1'b1, 8'h00, 1'b0);
    repeat (TOTAL + 1) step(1'b0, 8'h00, 1'b0);

    // abort during the third payload bit, then a clean frame
    step(1'b1, 8'hE7, 1'b0);
    repeat (SEQ_LEN + 2) step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    repeat (3) step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h96, 1'b0);
    repeat (TOTAL + 1) step(1'b0, 8'h00, 1'b0);

    // abort in the last payload cycle
    step(1'b1, 8'h81, 1'b0);
    repeat (FLEN - 1) step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    repeat (2) step(1'b0, 8'h00, 1'b0);

    // asynchronous reset mid-header
    step(1'b1, 8'hC3, 1'b0);
    repeat (3) step(1'b0, 8'h00, 1'b0);
    reset_mid();
    step(1'b1, 8'h71, 1'b0);
    repeat (TOTAL + 1) step(1'b0, 8'h00, 1'b0);

    // payload input churns and valid pulses while the frame is in flight
    step(1'b1, 8'h3C, 1'b0);
    repeat (TOTAL) step(1'($urandom % 2), 8'($urandom), 1'b0);
    repeat (TOTAL + 1) step(1'b0, 8'($urandom), 1'b0);

    // randomized traffic with occasional aborts
    repeat (800) step(($urandom % 4) != 0, 8'($urandom), ($urandom % 30) == 0);
    repeat (TOTAL + 2) step(1'b0, 8'h00, 1'b0);

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pat_frame_tx.md
Name: pat_frame_tx

Overview:
Serial frame transmitter. It is the transmit-side counterpart to the team's serial pattern detector.
- Accepts a parallel payload word over a valid/ready handshake.
- Emits on one serial line, one bit per clock, MSB first: a fixed sync header PAT, then the payload, then an idle gap.
- Drives the x_i input of a downstream pattern detector. The header is what that detector locks onto.

Parameters:
SEQ_LEN, 8, header length in bits (>=2)
PAT, 8'b1010_1100, header pattern, SEQ_LEN bits, sent MSB first
DATA_W, 8, payload width in bits (>=1)
GAP_CYCLES, 2, idle cycles after each frame (>=0)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
in_data_i  input  DATA_W  payload word
in_valid_i  input  1  payload valid
in_ready_o  output  1  transmitter can accept a payload
abort_i  input  1  synchronous frame abort
x_o  output  1  serial data bit
x_vld_o  output  1  x_o carries a frame bit this cycle
busy_o  output  1  frame or gap in progress
done_o  output  1  one-cycle pulse with the last payload bit

Behaviour:
- Reset is asynchronous and active-high. Clock is clk, rising edge. All state updates on the rising edge of clk.
- Reset values:
  - state = IDLE; header/payload shift registers and counters = 0.
  - x_o = 0, x_vld_o = 0, done_o = 0, busy_o = 0.
  - in_ready_o = 1 as soon as reset deasserts.
- x_o, x_vld_o and done_o are registered outputs.
- busy_o = (state != IDLE).
- in_ready_o = (state == IDLE) && !abort_i.
- State machine IDLE -> HDR -> DATA -> GAP -> IDLE:
  - IDLE: x_o = 0, x_vld_o = 0. Handshake = in_valid_i && in_ready_o at edge N.
    - At edge N: capture in_data_i, load PAT, set x_o <= PAT[SEQ_LEN-1], x_vld_o <= 1, go to HDR.
    - The first header bit is visible in the cycle after edge N.
  - HDR: SEQ_LEN cycles presenting PAT[SEQ_LEN-1] down to PAT[0]. The edge ending the final header cycle loads the payload MSB and goes to DATA.
  - DATA: DATA_W cycles presenting in_data[DATA_W-1] down to in_data[0].
    - done_o = 1 exactly in the cycle that presents in_data[0].
    - The following edge clears x_vld_o and x_o.
    - Next state is GAP, or IDLE if GAP_CYCLES = 0.
  - GAP: GAP_CYCLES cycles with x_o = 0, x_vld_o = 0, busy_o = 1, in_ready_o = 0. Then go to IDLE.
- Frame timing:
  - x_vld_o stays high for exactly SEQ_LEN + DATA_W consecutive cycles.
  - Minimum handshake-to-handshake spacing is SEQ_LEN + DATA_W + GAP_CYCLES + 1 cycles. The +1 is the mandatory IDLE cycle.
- The payload is captured at the handshake. in_data_i changes after the handshake have no effect on the frame in flight.
- in_valid_i outside IDLE is ignored. No data is captured and there is no queueing.
- abort_i:
  - Sampled in every state.
  - In HDR, DATA or GAP: the next edge forces state = IDLE, x_o = 0, x_vld_o = 0, and done_o is not pulsed.
  - In IDLE: abort_i suppresses the handshake (in_ready_o = 0).
- Simultaneous events:
  - abort_i in the last DATA cycle: done_o still shows 1 in that cycle, because it is already registered. The next state is IDLE, skipping GAP.
  - in_valid_i high continuously: a new frame starts on the first IDLE cycle after the gap.
- Asserting reset mid-frame immediately forces all outputs to their reset values. The partial frame is discarded.
- Counters are sized to clog2 of the max of SEQ_LEN, DATA_W, GAP_CYCLES. No wrap beyond the terminal count.

Test Plan:
1. Reset, then handshake with in_data_i = 8'h5A.
   -> x_o over 16 valid cycles = 1,0,1,0,1,1,0,0, 0,1,0,1,1,0,1,0.
   -> done_o high on the 16th valid cycle only.
   -> 2 gap cycles with x_vld_o = 0, then in_ready_o = 1.
2. Hold in_valid_i high with payloads 8'hFF then 8'h00.
   -> Second frame's first header bit appears exactly 19 cycles after the first frame's first header bit.
   -> Header unchanged; payload bits all 1 then all 0.
3. Drive x_o into the pattern detector (SEQ_LEN = 8, PAT = 8'hAC).
   -> det_o = 1 for exactly one cycle, the cycle after the 8th header bit.
   -> For payload 8'hAC, det_o = 1 a second time, the cycle after the payload LSB.
4. Assert abort_i for 1 cycle during the 3rd payload bit.
   -> Next cycle: x_vld_o = 0, busy_o = 0, in_ready_o = 1, and done_o never pulses.
   -> A new handshake then sends a complete, correct frame.
5. Assert reset asynchronously mid-header.
   -> x_o, x_vld_o, done_o, busy_o = 0 immediately.
   -> After release, in_ready_o = 1 and the next frame is correct.
6. Change in_data_i every cycle after the handshake of 8'h3C.
   -> Transmitted payload = 0,0,1,1,1,1,0,0.
   -> in_valid_i pulses during HDR, DATA and GAP are not accepted.
